// File: rtl/apb_uart_master_arb.sv
`default_nettype none
// ============================================================================
// apb_uart_master_arb : two-requester round-robin APB master for a UART slave
// Optional feature macro: ARB_TIMEOUT_EN (ACCESS-phase wait timeout)
// Revision: 1.0
// ============================================================================
module apb_uart_master_arb #(
   parameter int         ADDR_WIDTH     = 16,
   parameter int         DATA_WIDTH     = 32,
   parameter logic [2:0] PPROT_VAL      = 3'b000,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_write,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic [3:0]            req0_strb,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp0_err,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_write,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic [3:0]            req1_strb,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  rsp1_err,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic [2:0]            PPROT,
   output logic                  PSELx,
   output logic                  PENABLE,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   output logic [3:0]            PSTRB,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PSLVERR,
   input  logic                  PREADY
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2,
      S_RESP   = 2'd3
   } state_t;

   state_t                r_state, w_state_nxt;
   logic                  r_ready0, r_ready1, w_ready0_nxt, w_ready1_nxt;
   logic                  r_gid, w_gid_nxt;
   logic                  r_ptr, w_ptr_nxt;
   logic                  r_psel, r_penable, r_pwrite;
   logic                  w_psel_nxt, w_penable_nxt, w_pwrite_nxt;
   logic [ADDR_WIDTH-1:0] r_paddr, w_paddr_nxt;
   logic [DATA_WIDTH-1:0] r_pwdata, w_pwdata_nxt;
   logic [3:0]            r_pstrb, w_pstrb_nxt;
   logic [2:0]            r_pprot;
   logic                  r_rsp0_valid, r_rsp1_valid, r_rsp0_err, r_rsp1_err;
   logic [DATA_WIDTH-1:0] r_rsp0_rdata, r_rsp1_rdata;
   logic                  w_rsp0_valid_nxt, w_rsp1_valid_nxt, w_rsp0_err_nxt, w_rsp1_err_nxt;
   logic [DATA_WIDTH-1:0] w_rsp0_rdata_nxt, w_rsp1_rdata_nxt;
   logic                  w_fire, w_err;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_grant0, w_grant1, w_tie;

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
`else
   if (TIMEOUT_CYCLES < 0) begin : g_no_timeout
   end
`endif

   // Pointer only matters on a tie; a lone requester is granted regardless.
   assign w_tie    = req0_valid & req1_valid;
   assign w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
   assign w_grant1 = req1_valid & (~req0_valid |  r_ptr);

   always_comb begin
      w_state_nxt      = r_state;
      w_ready0_nxt     = 1'b0;
      w_ready1_nxt     = 1'b0;
      w_gid_nxt        = r_gid;
      w_ptr_nxt        = r_ptr;
      w_psel_nxt       = r_psel;
      w_penable_nxt    = r_penable;
      w_pwrite_nxt     = r_pwrite;
      w_paddr_nxt      = r_paddr;
      w_pwdata_nxt     = r_pwdata;
      w_pstrb_nxt      = r_pstrb;
      w_fire           = 1'b0;
      w_err            = 1'b0;
      w_data           = '0;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt        = r_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            // A visible ready pulse is the accept cycle; the command is already latched.
            if (r_ready0 | r_ready1) begin
               w_state_nxt = S_SETUP;
               w_psel_nxt  = 1'b1;
            end else if (w_grant0 | w_grant1) begin
               w_ready0_nxt = w_grant0;
               w_ready1_nxt = w_grant1;
               w_gid_nxt    = w_grant1;
               if (w_tie) w_ptr_nxt = ~w_grant1;
               w_pwrite_nxt = w_grant1 ? req1_write : req0_write;
               w_paddr_nxt  = w_grant1 ? req1_addr  : req0_addr;
               w_pwdata_nxt = w_grant1 ? req1_wdata : req0_wdata;
               w_pstrb_nxt  = w_grant1 ? req1_strb  : req0_strb;
            end
         end
         S_SETUP: begin
            w_state_nxt   = S_ACCESS;
            w_penable_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
            w_cnt_nxt     = '0;
`endif
         end
         S_ACCESS: begin
            if (PREADY) begin
               w_fire = 1'b1;
               w_err  = PSLVERR;
               w_data = r_pwrite ? '0 : PRDATA;
            end
`ifdef ARB_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_fire = 1'b1;
               w_err  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
`endif
            if (w_fire) begin
               w_state_nxt   = S_RESP;
               w_psel_nxt    = 1'b0;
               w_penable_nxt = 1'b0;
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      w_rsp0_valid_nxt = w_fire & ~r_gid;
      w_rsp1_valid_nxt = w_fire &  r_gid;
      w_rsp0_err_nxt   = w_fire & ~r_gid & w_err;
      w_rsp1_err_nxt   = w_fire &  r_gid & w_err;
      w_rsp0_rdata_nxt = (w_fire & ~r_gid) ? w_data : '0;
      w_rsp1_rdata_nxt = (w_fire &  r_gid) ? w_data : '0;
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state      <= S_IDLE;
         r_ready0     <= 1'b0;
         r_ready1     <= 1'b0;
         r_gid        <= 1'b0;
         r_ptr        <= 1'b0;
         r_psel       <= 1'b0;
         r_penable    <= 1'b0;
         r_pwrite     <= 1'b0;
         r_paddr      <= '0;
         r_pwdata     <= '0;
         r_pstrb      <= 4'b0000;
         r_pprot      <= PPROT_VAL;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
         r_rsp0_err   <= 1'b0;
         r_rsp1_err   <= 1'b0;
         r_rsp0_rdata <= '0;
         r_rsp1_rdata <= '0;
`ifdef ARB_TIMEOUT_EN
         r_cnt        <= '0;
`endif
      end else begin
         r_state      <= w_state_nxt;
         r_ready0     <= w_ready0_nxt;
         r_ready1     <= w_ready1_nxt;
         r_gid        <= w_gid_nxt;
         r_ptr        <= w_ptr_nxt;
         r_psel       <= w_psel_nxt;
         r_penable    <= w_penable_nxt;
         r_pwrite     <= w_pwrite_nxt;
         r_paddr      <= w_paddr_nxt;
         r_pwdata     <= w_pwdata_nxt;
         r_pstrb      <= w_pstrb_nxt;
         r_pprot      <= PPROT_VAL;
         r_rsp0_valid <= w_rsp0_valid_nxt;
         r_rsp1_valid <= w_rsp1_valid_nxt;
         r_rsp0_err   <= w_rsp0_err_nxt;
         r_rsp1_err   <= w_rsp1_err_nxt;
         r_rsp0_rdata <= w_rsp0_rdata_nxt;
         r_rsp1_rdata <= w_rsp1_rdata_nxt;
`ifdef ARB_TIMEOUT_EN
         r_cnt        <= w_cnt_nxt;
`endif
      end
   end

   assign req0_ready = r_ready0;
   assign req1_ready = r_ready1;
   assign rsp0_valid = r_rsp0_valid;
   assign rsp1_valid = r_rsp1_valid;
   assign rsp0_err   = r_rsp0_err;
   assign rsp1_err   = r_rsp1_err;
   assign rsp0_rdata = r_rsp0_rdata;
   assign rsp1_rdata = r_rsp1_rdata;
   assign PADDR      = r_paddr;
   assign PPROT      = r_pprot;
   assign PSELx      = r_psel;
   assign PENABLE    = r_penable;
   assign PWRITE     = r_pwrite;
   assign PWDATA     = r_pwdata;
   assign PSTRB      = r_pstrb;

endmodule
`default_nettype wire

// File: tb/tb_apb_uart_master_arb.sv
`default_nettype none
// tb_apb_uart_master_arb : directed/randomized bench with an inline APB slave
// and a transaction-level model of grant order and responses.
module tb_apb_uart_master_arb;
   localparam int         AW = 16;
   localparam int         DW = 32;
   localparam int         TO = 16;
   localparam logic [2:0] PP = 3'b101;

   logic          PCLK = 1'b0;
   logic          PRESET;
   logic          req0_valid, req0_ready, req0_write;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata;
   logic [3:0]    req0_strb;
   logic          rsp0_valid, rsp0_err;
   logic [DW-1:0] rsp0_rdata;
   logic          req1_valid, req1_ready, req1_write;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata;
   logic [3:0]    req1_strb;
   logic          rsp1_valid, rsp1_err;
   logic [DW-1:0] rsp1_rdata;
   logic [AW-1:0] PADDR;
   logic [2:0]    PPROT;
   logic          PSELx, PENABLE, PWRITE, PSLVERR, PREADY;
   logic [DW-1:0] PWDATA, PRDATA;
   logic [3:0]    PSTRB;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: last command per requester and the round-robin preference.
   logic          c_write [2];
   logic [AW-1:0] c_addr  [2];
   logic [DW-1:0] c_wdata [2];
   logic [3:0]    c_strb  [2];
   int            m_ptr;

   always #5 PCLK = ~PCLK;

   apb_uart_master_arb #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PPROT_VAL(PP), .TIMEOUT_CYCLES(TO)
   ) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
      .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_strb(req0_strb),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
      .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_strb(req1_strb),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .PADDR(PADDR), .PPROT(PPROT), .PSELx(PSELx), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
      .PSLVERR(PSLVERR), .PREADY(PREADY)
   );

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_req(input int id, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [3:0] s);
      c_write[id] = w; c_addr[id] = a; c_wdata[id] = d; c_strb[id] = s;
      if (id == 0) begin
         req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d; req0_strb = s;
      end else begin
         req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d; req1_strb = s;
      end
   endtask

   task automatic drop_req(input int id);
      if (id == 0) req0_valid = 1'b0;
      else         req1_valid = 1'b0;
   endtask

   task automatic wait_grant(output int gid);
      gid = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge PCLK);
         if (req0_ready || req1_ready) break;
      end
      if (req0_ready && !req1_ready)      gid = 0;
      else if (req1_ready && !req0_ready) gid = 1;
   endtask

   // One complete transfer: grant, SETUP, ACCESS with wait states, RESP, back to IDLE.
   task automatic transact(input int exp_id, input int waits, input logic slverr,
                           input logic [DW-1:0] rd, input string tag);
      int gid;
      logic [DW-1:0] exp_rd;
      wait_grant(gid);
      check({tag, " grant"}, gid, exp_id);
      drop_req(exp_id);
      @(negedge PCLK);
      check({tag, " ready pulse"}, {req0_ready, req1_ready}, 0);
      check({tag, " setup sel/en"}, {PSELx, PENABLE}, 2'b10);
      check({tag, " paddr"}, PADDR, c_addr[exp_id]);
      check({tag, " pwrite"}, PWRITE, c_write[exp_id]);
      check({tag, " pstrb"}, PSTRB, c_strb[exp_id]);
      check({tag, " pprot"}, PPROT, PP);
      if (c_write[exp_id]) check({tag, " pwdata"}, PWDATA, c_wdata[exp_id]);
      for (int k = 0; k <= waits; k++) begin
         @(negedge PCLK);
         check({tag, " access sel/en"}, {PSELx, PENABLE}, 2'b11);
         check({tag, " access paddr"}, PADDR, c_addr[exp_id]);
         PREADY  = (k == waits);
         PRDATA  = (k == waits) ? rd : DW'($urandom);
         PSLVERR = (k == waits) ? slverr : 1'b1;
      end
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
      exp_rd = c_write[exp_id] ? '0 : rd;
      check({tag, " idle sel/en"}, {PSELx, PENABLE}, 2'b00);
      if (exp_id == 0) begin
         check({tag, " rsp0 valid/err"}, {rsp0_valid, rsp0_err}, {1'b1, slverr});
         check({tag, " rsp0 rdata"}, rsp0_rdata, exp_rd);
         check({tag, " rsp1 quiet"}, {rsp1_valid, rsp1_err, rsp1_rdata}, 0);
      end else begin
         check({tag, " rsp1 valid/err"}, {rsp1_valid, rsp1_err}, {1'b1, slverr});
         check({tag, " rsp1 rdata"}, rsp1_rdata, exp_rd);
         check({tag, " rsp0 quiet"}, {rsp0_valid, rsp0_err, rsp0_rdata}, 0);
      end
      @(negedge PCLK);
      check({tag, " rsp drop"}, {rsp0_valid, rsp1_valid}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int gid, n, nrsp, q0, q1, exp;
      PRESET = 1'b1;
      req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0; req0_strb = '0;
      req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0; req1_strb = '0;
      PRDATA = '0; PSLVERR = 1'b0; PREADY = 1'b0;
      repeat (3) @(negedge PCLK);
      check("reset ctrl", {PSELx, PENABLE, PWRITE, req0_ready, req1_ready,
                           rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 0);
      check("reset data", {PADDR, PSTRB}, 0);
      check("reset pwdata", PWDATA, 0);
      check("reset rdata", rsp0_rdata | rsp1_rdata, 0);
      check("reset pprot", PPROT, PP);
      PRESET = 1'b0;
      m_ptr  = 0;

      load_req(0, 1'b1, 16'h4000, 32'hDEADBEEF, 4'b1111);
      transact(0, 0, 1'b0, DW'($urandom), "wr0");

      // Continuous contention: 4 commands per requester.
      q0 = 4; q1 = 4;
      for (int i = 0; i < 8; i++) begin
         if (q0 > 0 && !req0_valid)
            load_req(0, 1'($urandom_range(0, 1)), 16'h4000 + AW'($urandom_range(0, 15) * 4),
                     DW'($urandom), 4'($urandom));
         if (q1 > 0 && !req1_valid)
            load_req(1, 1'($urandom_range(0, 1)), 16'h4000 + AW'($urandom_range(0, 15) * 4),
                     DW'($urandom), 4'($urandom));
         if (q0 > 0 && q1 > 0) begin
            exp   = m_ptr;
            m_ptr = 1 - exp;
         end else begin
            exp = (q0 > 0) ? 0 : 1;
         end
         transact(exp, $urandom_range(0, 3), 1'b0, DW'($urandom), "contend");
         if (exp == 0) q0--; else q1--;
      end

      load_req(1, 1'b0, 16'h4008, DW'($urandom), 4'b1111);
      transact(1, 3, 1'b0, 32'h000000EF, "rd1 wait3");

      load_req(0, 1'b1, 16'h4001, DW'($urandom), 4'b0001);
      transact(0, 0, 1'b1, DW'($urandom), "wr0 slverr");
      load_req(0, 1'b0, 16'h4004, DW'($urandom), 4'b1111);
      transact(0, 2, 1'b0, DW'($urandom), "rd0 after err");

`ifdef ARB_TIMEOUT_EN
      load_req(0, 1'b0, 16'h4010, '0, 4'b1111);
      wait_grant(gid);
      check("timeout grant", gid, 0);
      drop_req(0);
      @(negedge PCLK);
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge PCLK);
         if (PSELx && PENABLE) n++;
         else break;
      end
      check("timeout access cycles", n, TO);
      check("timeout rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b11, 32'h0});
      check("timeout rsp1 quiet", rsp1_valid, 1'b0);
      @(negedge PCLK);
      load_req(0, 1'b0, 16'h4014, '0, 4'b1111);
      wait_grant(gid);
      drop_req(0);
      @(negedge PCLK);
      repeat (5) @(negedge PCLK);
`else
      load_req(0, 1'b0, 16'h4010, '0, 4'b1111);
      wait_grant(gid);
      check("hang grant", gid, 0);
      drop_req(0);
      @(negedge PCLK);
      n = 0;
      for (int k = 0; k < 110; k++) begin
         @(negedge PCLK);
         if (PSELx && PENABLE) n++;
      end
      check("hang sel held", n, 110);
`endif
      // Asynchronous reset in the middle of an ACCESS phase.
      #2 PRESET = 1'b1;
      #1 check("async reset sel/en", {PSELx, PENABLE}, 2'b00);
      nrsp = 0;
      repeat (3) begin
         @(negedge PCLK);
         if (rsp0_valid || rsp1_valid) nrsp++;
      end
      PRESET = 1'b0;
      @(negedge PCLK);
      if (rsp0_valid || rsp1_valid) nrsp++;
      check("no rsp after reset", nrsp, 0);
      m_ptr = 0;

      load_req(0, 1'b1, 16'h4020, DW'($urandom), 4'b1111);
      load_req(1, 1'b1, 16'h4024, DW'($urandom), 4'b1111);
      transact(m_ptr, 0, 1'b0, DW'($urandom), "post-reset tie");
      m_ptr = 1;
      transact(1, 1, 1'b0, DW'($urandom), "post-reset second");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/apb_uart_master_arb.md
Name: apb_uart_master_arb

Overview:
- Two-requester APB master that shares the single APB UART slave (UART_wrapper, 16-bit address, 32-bit data) between two on-chip clients, e.g. a CPU port and a DMA/loopback engine.
- Accepts one command at a time from either requester.
- Sequences the APB SETUP/ACCESS phases to the slave.
- Returns read data and error status to the requester that issued the command.
- Arbitration between the requesters is round-robin.

Parameters:
- ADDR_WIDTH, 16, APB address width.
- DATA_WIDTH, 32, APB data width.
- PPROT_VAL, 3'b000, constant driven on PPROT for every transfer.
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit; used only when ARB_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  asynchronous active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted; 1-cycle pulse.
- req0_write  in  1  1=write, 0=read.
- req0_addr  in  ADDR_WIDTH  target address.
- req0_wdata  in  DATA_WIDTH  write data.
- req0_strb  in  4  byte strobes.
- rsp0_valid  out  1  response pulse to requester 0.
- rsp0_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp0_err  out  1  slave error or timeout.
- req1_valid, req1_ready, req1_write, req1_addr, req1_wdata, req1_strb, rsp1_valid, rsp1_rdata, rsp1_err: same as requester 0, for requester 1.
- PADDR  out  ADDR_WIDTH  APB address.
- PPROT  out  3  APB protection.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  4  APB strobes.
- PRDATA  in  DATA_WIDTH  APB read data.
- PSLVERR  in  1  APB slave error.
- PREADY  in  1  APB ready.

Behaviour:
- Clock/reset: single clock PCLK; PRESET is asynchronous and active-high. All outputs are registered.
- Reset values:
  - PSELx, PENABLE, PWRITE, reqN_ready, rspN_valid, rspN_err = 0.
  - PADDR, PWDATA, rspN_rdata = 0; PSTRB = 4'b0000.
  - PPROT = PPROT_VAL.
  - Round-robin pointer = 0, so requester 0 wins the first tie.
  - State = IDLE.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Grant rule: if exactly one reqN_valid is high, grant that requester. If both are high, grant the requester the pointer favours, then point the pointer at the other requester.
  - On grant: pulse reqN_ready for 1 cycle, latch write/addr/wdata/strb and the grant id, go to SETUP.
  - No valid: stay in IDLE.
- SETUP (1 cycle): PSELx=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB from the latched command; next state ACCESS.
- ACCESS:
  - Drive PSELx=1, PENABLE=1; all APB outputs are held stable.
  - When PREADY=1: capture PRDATA (reads only; writes capture 0) and PSLVERR, drop PSELx/PENABLE on the next edge, go to RESP.
- RESP (1 cycle): rspN_valid=1 for the granted requester only, with rdata/err. The other requester's rsp outputs stay 0. Next state IDLE.
- Latency: accept cycle T, SETUP T+1, ACCESS T+2 (PREADY=1 there gives zero wait states), rsp at T+3. Minimum 4 cycles per transfer; each wait state adds 1 cycle.
- Requester contract:
  - reqN_valid must stay high and the command stable until reqN_ready.
  - reqN_ready is never asserted outside IDLE; a request arriving while busy waits.
- Fairness: under continuous contention, grants alternate 0,1,0,1.
- PSLVERR is sampled only in the ACCESS cycle where PREADY=1.
- Reset mid-transfer: PSELx/PENABLE deassert asynchronously, no rsp is issued, the in-flight command is dropped, the pointer returns to 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
  - When the count reaches TIMEOUT_CYCLES, PSELx/PENABLE deassert and the FSM goes to RESP with rspN_err=1, rspN_rdata=0.
- Not defined: no counter; ACCESS waits indefinitely for PREADY.

Test Plan:
- req0 write addr 0x4000, wdata 0xDEADBEEF, strb 4'b1111, PREADY tied 1 -> SETUP then ACCESS with PADDR=0x4000, PWDATA=0xDEADBEEF, PWRITE=1; rsp0_valid 3 cycles after req0_ready; rsp0_err=0, rsp0_rdata=0.
- req0 and req1 both valid in the same cycle, 4 back-to-back commands each -> grant order 0,1,0,1,0,1,0,1; no rsp lands on the wrong requester.
- req1 read addr 0x4008, slave returns 0x000000EF after 3 wait states -> ACCESS lasts 4 cycles, PWRITE=0; rsp1_rdata=0x000000EF, rsp1_err=0.
- req0 write addr 0x4001, slave asserts PSLVERR with PREADY -> rsp0_err=1; the next transfer's rsp_err returns to 0.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, PREADY held 0 -> PSELx drops after 16 ACCESS cycles; rsp0_err=1, rsp0_rdata=0. Without the macro, PSELx stays high for more than 100 cycles.
- PRESET asserted during ACCESS -> PSELx/PENABLE go 0 asynchronously, no rsp pulse; after release, a tie grants requester 0 first.
